// File: rtl/ppm_tx.sv
// 8-slot PPM transmitter: frames a valid/ready symbol stream as a slot-0 preamble,
// one pulse per data symbol, then a dark guard gap.
module ppm_tx #(
    parameter int SLOTS         = 8,
    parameter int SLOT_CLKS     = 250,
    parameter int PULSE_CLKS    = 25,
    parameter int PREAMBLE_SYMS = 8,
    parameter int GAP_SYMS      = 2,
    localparam int SYM_W        = $clog2(SLOTS)
) (
    input  logic             clk10m,
    input  logic             reset_n,
    input  logic [SYM_W-1:0] sym_data,
    input  logic             sym_valid,
    input  logic             sym_last,
    output logic             sym_ready,
    output logic             txdata,
    output logic             ppm_clk,
    output logic             busy,
    output logic             underrun,
    output logic             frame_done,
    output logic [1:0]       state_dbg
);

    localparam int SC_W    = $clog2(SLOT_CLKS);
    localparam int CNT_MAX = (PREAMBLE_SYMS > GAP_SYMS) ? PREAMBLE_SYMS : GAP_SYMS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [SC_W-1:0]  SLOT_LAST = SC_W'(SLOT_CLKS - 1);
    localparam logic [SC_W-1:0]  PULSE_LIM = SC_W'(PULSE_CLKS);
    localparam logic [SC_W-1:0]  HALF_SLOT = SC_W'(SLOT_CLKS / 2);
    localparam logic [SYM_W-1:0] IDX_LAST  = SYM_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_SYMS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_SYMS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PRE  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]       state;
    logic [SC_W-1:0]  slot_cnt;
    logic [SYM_W-1:0] slot_idx;
    logic [CNT_W-1:0] sym_cnt;
    logic [SYM_W-1:0] cur_sym;
    logic             last_q;

    logic             eos;
    logic             ready_point;
    logic             active;
    logic [SYM_W-1:0] pulse_slot;

    // Handshake: the source holds sym_valid/sym_data/sym_last; a symbol moves on
    // any edge where sym_valid && sym_ready. sym_ready depends only on internal
    // state, never on sym_valid, and is high for one cycle at a symbol boundary.
    assign eos         = (slot_cnt == SLOT_LAST) && (slot_idx == IDX_LAST);
    assign ready_point = eos && (((state == ST_PRE) && (sym_cnt == PRE_LAST)) ||
                                 ((state == ST_DATA) && !last_q));
    assign sym_ready   = ready_point;
    assign active      = (state == ST_PRE) || (state == ST_DATA);
    assign pulse_slot  = (state == ST_DATA) ? cur_sym : '0;
    assign busy        = (state != ST_IDLE);
    assign state_dbg   = state;

    // In-symbol position; parked at zero in IDLE so a new frame starts aligned.
    always_ff @(posedge clk10m or negedge reset_n) begin
        if (!reset_n) begin
            slot_cnt <= '0;
            slot_idx <= '0;
        end else if (state == ST_IDLE) begin
            slot_cnt <= '0;
            slot_idx <= '0;
        end else if (slot_cnt == SLOT_LAST) begin
            slot_cnt <= '0;
            slot_idx <= eos ? '0 : slot_idx + SYM_W'(1);
        end else begin
            slot_cnt <= slot_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk10m or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sym_cnt    <= '0;
            cur_sym    <= '0;
            last_q     <= 1'b0;
            underrun   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            underrun   <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (sym_valid) begin
                        state   <= ST_PRE;
                        sym_cnt <= '0;
                    end
                end
                ST_PRE: begin
                    if (eos && (sym_cnt != PRE_LAST)) begin
                        sym_cnt <= sym_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (eos && last_q) begin
                        state   <= ST_GAP;
                        sym_cnt <= '0;
                    end
                end
                ST_GAP: begin
                    if (eos) begin
                        if (sym_cnt == GAP_LAST) begin
                            state      <= ST_IDLE;
                            frame_done <= 1'b1;
                            sym_cnt    <= '0;
                        end else begin
                            sym_cnt <= sym_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    sym_cnt <= '0;
                end
            endcase

            // A ready point with no data aborts the frame into the guard gap.
            if (ready_point) begin
                if (sym_valid) begin
                    cur_sym <= sym_data;
                    last_q  <= sym_last;
                    state   <= ST_DATA;
                end else begin
                    underrun <= 1'b1;
                    state    <= ST_GAP;
                    sym_cnt  <= '0;
                end
            end
        end
    end

    // Registered drive outputs, one cycle behind the position counters.
    always_ff @(posedge clk10m or negedge reset_n) begin
        if (!reset_n) begin
            txdata  <= 1'b0;
            ppm_clk <= 1'b0;
        end else begin
            txdata  <= active && (slot_idx == pulse_slot) && (slot_cnt < PULSE_LIM);
            ppm_clk <= active && (slot_cnt < HALF_SLOT);
        end
    end

endmodule

// File: tb/tb_ppm_tx.sv
// Directed bench for ppm_tx: reset, preamble, stream, underrun and empty-frame cases,
// run with SLOT_CLKS=100 / PULSE_CLKS=10 so a symbol is 800 cycles.
module tb_ppm_tx;

  localparam int SLOT_CLKS  = 100;
  localparam int PULSE_CLKS = 10;
  localparam int SYM_P      = 800;
  localparam int NEVER      = 1000000;

  logic       clk10m = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] sym_data = 3'd0;
  logic       sym_valid = 1'b0;
  logic       sym_last = 1'b0;
  logic       sym_ready, txdata, ppm_clk, busy, underrun, frame_done;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_rise[$];
  logic [31:0] got_fall[$];
  logic [31:0] got_rdy[$];
  logic [31:0] got_und[$];
  logic [31:0] got_done[$];
  logic [3:0]  src_q[$];
  int          ppm_rise, ppm_high, busy_fall;

  ppm_tx #(
    .SLOTS(8), .SLOT_CLKS(SLOT_CLKS), .PULSE_CLKS(PULSE_CLKS),
    .PREAMBLE_SYMS(8), .GAP_SYMS(2)
  ) dut (
    .clk10m(clk10m), .reset_n(reset_n), .sym_data(sym_data), .sym_valid(sym_valid),
    .sym_last(sym_last), .sym_ready(sym_ready), .txdata(txdata), .ppm_clk(ppm_clk),
    .busy(busy), .underrun(underrun), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // clock/reset block
  always #50 clk10m = ~clk10m;
  always @(posedge clk10m) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cmp_q(input string tag, input int kind);
    logic [31:0] g[$];
    case (kind)
      0: g = got_rise;
      1: g = got_fall;
      2: g = got_rdy;
      3: g = got_und;
      default: g = got_done;
    endcase
    check({tag, "_count"}, g.size(), exp_q.size());
    for (int i = 0; i < g.size() && i < exp_q.size(); i++) check(tag, g[i], exp_q[i]);
    exp_q.delete();
  endtask

  // Drives src_q through the handshake for n_cyc cycles and logs events with
  // times relative to the first active-state cycle (t=0).
  task automatic run_frame(input int n_cyc, input int stop_t);
    int base, t;
    logic p_tx, p_ppm, p_busy, want;
    logic [3:0] v;
    got_rise.delete(); got_fall.delete(); got_rdy.delete();
    got_und.delete(); got_done.delete();
    ppm_rise = 0; ppm_high = 0; busy_fall = -1;
    p_tx = 1'b0; p_ppm = 1'b0; p_busy = 1'b0;
    @(negedge clk10m);
    base = cyc + 1;
    for (int i = 0; i < n_cyc; i++) begin
      if (i > 0) @(negedge clk10m);
      t = cyc - base;
      if (txdata && !p_tx) got_rise.push_back(t);
      if (!txdata && p_tx) got_fall.push_back(t);
      if (sym_ready) got_rdy.push_back(t);
      if (underrun) got_und.push_back(t);
      if (frame_done) got_done.push_back(t);
      if (!busy && p_busy) busy_fall = t;
      if (ppm_clk && !p_ppm) ppm_rise++;
      if (ppm_clk) ppm_high++;
      p_tx = txdata; p_ppm = ppm_clk; p_busy = busy;
      want = (src_q.size() > 0) && (t < stop_t);
      sym_valid = want;
      if (sym_ready && want) begin
        v = src_q.pop_front();
        sym_data = v[2:0];
        sym_last = v[3];
      end else begin
        sym_data = 3'($urandom_range(0, 7));
        sym_last = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk10m);
    sym_valid = 1'b0;
    src_q.delete();
  endtask

  task automatic exp_preamble(input int off);
    for (int k = 0; k < 8; k++) exp_q.push_back(1 + off + k * SYM_P);
  endtask

  initial begin
    // reset values
    repeat (3) @(negedge clk10m);
    check("rst_txdata", txdata, 0);
    check("rst_ppm_clk", ppm_clk, 0);
    check("rst_busy", busy, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sym_ready", sym_ready, 0);
    check("rst_state", state_dbg, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk10m);

    // reset in the middle of the first preamble pulse
    sym_data = 3'd5; sym_last = 1'b1; sym_valid = 1'b1;
    @(negedge clk10m);
    sym_valid = 1'b0;
    repeat (4) @(negedge clk10m);
    check("mid_txdata_high", txdata, 1);
    check("mid_busy_high", busy, 1);
    check("mid_ppm_high", ppm_clk, 1);
    #10 reset_n = 1'b0;
    #1;
    check("async_txdata", txdata, 0);
    check("async_busy", busy, 0);
    check("async_ppm_clk", ppm_clk, 0);
    @(negedge clk10m);
    reset_n = 1'b1;
    run_frame(1000, NEVER);
    cmp_q("idle_rise", 0);
    cmp_q("idle_done", 4);
    check("idle_ppm_high", ppm_high, 0);
    check("idle_busy_fall", busy_fall, -1);

    // preamble check: single symbol 3 flagged last
    src_q.push_back(4'b1011);
    run_frame(8900, NEVER);
    exp_preamble(0); exp_q.push_back(6701); cmp_q("pre_rise", 0);
    exp_preamble(PULSE_CLKS); exp_q.push_back(6711); cmp_q("pre_fall", 1);
    exp_q.push_back(6399); cmp_q("pre_ready", 2);
    cmp_q("pre_underrun", 3);
    exp_q.push_back(8800); cmp_q("pre_done", 4);
    check("pre_busy_fall", busy_fall, 8800);
    check("pre_ppm_rise", ppm_rise, 72);
    check("pre_ppm_high", ppm_high, 3600);

    // stream check: 0,7,5,2 back-to-back, last on 2
    src_q.push_back(4'b0000); src_q.push_back(4'b0111);
    src_q.push_back(4'b0101); src_q.push_back(4'b1010);
    run_frame(11300, NEVER);
    exp_preamble(0);
    exp_q.push_back(6401); exp_q.push_back(7901); exp_q.push_back(8501); exp_q.push_back(9001);
    cmp_q("str_rise", 0);
    exp_preamble(PULSE_CLKS);
    exp_q.push_back(6411); exp_q.push_back(7911); exp_q.push_back(8511); exp_q.push_back(9011);
    cmp_q("str_fall", 1);
    exp_q.push_back(6399); exp_q.push_back(7199); exp_q.push_back(7999); exp_q.push_back(8799);
    cmp_q("str_ready", 2);
    cmp_q("str_underrun", 3);
    exp_q.push_back(11200); cmp_q("str_done", 4);
    check("str_busy_fall", busy_fall, 11200);
    check("str_ppm_rise", ppm_rise, 96);
    check("str_ppm_high", ppm_high, 4800);

    // underrun after two data symbols (1, 6)
    src_q.push_back(4'b0001); src_q.push_back(4'b0110);
    run_frame(9700, NEVER);
    exp_preamble(0); exp_q.push_back(6501); exp_q.push_back(7801); cmp_q("und_rise", 0);
    exp_q.push_back(6399); exp_q.push_back(7199); exp_q.push_back(7999); cmp_q("und_ready", 2);
    exp_q.push_back(8000); cmp_q("und_underrun", 3);
    exp_q.push_back(9600); cmp_q("und_done", 4);
    check("und_busy_fall", busy_fall, 9600);
    check("und_ppm_rise", ppm_rise, 80);

    // empty frame: valid drops during the preamble
    src_q.push_back(4'b0100);
    run_frame(8100, 3000);
    exp_preamble(0); cmp_q("emp_rise", 0);
    exp_q.push_back(6399); cmp_q("emp_ready", 2);
    exp_q.push_back(6400); cmp_q("emp_underrun", 3);
    exp_q.push_back(8000); cmp_q("emp_done", 4);
    check("emp_ppm_high", ppm_high, 3200);
    check("emp_end_state", state_dbg, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
